// File: rtl/branch_update_unit_pkg.sv
// Shared types and helpers for the branch update unit.
// PHT index is {ghr, pc[PC_IDX_LEN+1:2]}, so its width is GHR_LEN + PC_IDX_LEN.
package branch_update_unit_pkg;

    localparam int GHR_LEN                 = 5;
    localparam int PC_IDX_LEN              = 5;
    localparam int PATTERN_HISTORY_LEN     = GHR_LEN + PC_IDX_LEN;
    localparam int UPD_QUEUE_DEPTH_DEFAULT = 4;

    // One pending PHT write: target entry and the new 2-bit counter value.
    typedef struct packed {
        logic [PATTERN_HISTORY_LEN-1:0] idx;
        logic [1:0]                     val;
    } pht_upd_t;

    typedef enum logic {
        BU_RUN   = 1'b0,
        BU_FLUSH = 1'b1
    } bu_state_t;

    // 2-bit saturating increment: strongly-taken holds.
    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'd1;
    endfunction

    // 2-bit saturating decrement: strongly-not-taken holds.
    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'd1;
    endfunction

endpackage

// File: rtl/branch_update_queue.sv
// Small FIFO of pending PHT updates. Pointers carry an extra wrap bit so
// full and empty are distinguished without a separate counter.
module branch_update_queue
    import branch_update_unit_pkg::*;
#(
    parameter int DEPTH = UPD_QUEUE_DEPTH_DEFAULT
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push_i,
    input  pht_upd_t push_data_i,
    input  logic     pop_i,
    output pht_upd_t head_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    pht_upd_t    mem_q [DEPTH];

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; a push and a pop in the same cycle leave occupancy unchanged.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_i && !empty_o) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/branch_update_unit.sv
// Commit-side partner of the gshare predictor: takes resolved branches in
// program order, computes saturating counter updates, queues them for the
// single PHT write port and raises a one-cycle flush on mispredict.
// Optional feature macro: BR_PERF_CTR_EN adds saturating branch/mispredict counters.
module branch_update_unit
    import branch_update_unit_pkg::*;
#(
    parameter int UPD_QUEUE_DEPTH = UPD_QUEUE_DEPTH_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           commit_valid,
    output logic                           commit_ready,
    input  logic [31:0]                    commit_pc,
    input  logic [31:0]                    commit_target,
    input  logic                           commit_taken,
    input  logic [1:0]                     commit_pred,
    input  logic [PATTERN_HISTORY_LEN-1:0] commit_idx,
    output logic                           branch_write,
    output logic [1:0]                     updated_val,
    output logic [PATTERN_HISTORY_LEN-1:0] control_idx,
    output logic                           flush_out,
    output logic [31:0]                    redirect_pc
`ifdef BR_PERF_CTR_EN
    ,
    output logic [31:0]                    perf_branches,
    output logic [31:0]                    perf_mispredicts
`endif
);

    // Handshake: a commit transfers on a cycle where commit_valid && commit_ready;
    // ready is low during reset, in FLUSH, and whenever the queue is full.

    bu_state_t                      state_q;
    logic                           flush_q;
    logic [31:0]                    redirect_q;

    logic                           last_valid_q;
    logic [PATTERN_HISTORY_LEN-1:0] last_idx_q;
    logic [1:0]                     last_val_q;

    logic                           accept;
    logic                           mispredict;
    logic [1:0]                     base_val;
    logic [1:0]                     upd_val_d;
    pht_upd_t                       push_data;
    pht_upd_t                       q_head;
    logic                           q_full;
    logic                           q_empty;
    logic                           q_pop;

    assign commit_ready = !rst && !q_full && (state_q == BU_RUN);
    assign accept       = commit_valid && commit_ready;
    assign mispredict   = commit_pred[1] ^ commit_taken;

    // New counter value: start from the freshest known value for this entry.
    always_comb begin
        base_val = commit_pred;
        if (last_valid_q && (last_idx_q == commit_idx)) begin
            base_val = last_val_q;
        end
        upd_val_d = commit_taken ? sat_inc(base_val) : sat_dec(base_val);
    end

    assign push_data.idx = commit_idx;
    assign push_data.val = upd_val_d;

    branch_update_queue #(
        .DEPTH (UPD_QUEUE_DEPTH)
    ) u_queue (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (accept),
        .push_data_i (push_data),
        .pop_i       (q_pop),
        .head_o      (q_head),
        .full_o      (q_full),
        .empty_o     (q_empty)
    );

    // Head of queue goes straight to the PHT port; a reset cycle writes nothing.
    assign q_pop        = !q_empty && !rst;
    assign branch_write = !q_pop;
    assign control_idx  = q_pop ? q_head.idx : '0;
    assign updated_val  = q_pop ? q_head.val : 2'b00;

    // Remember the most recent accepted update so back-to-back hits on one entry chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_valid_q <= 1'b0;
            last_idx_q   <= '0;
            last_val_q   <= 2'b00;
        end else if (accept) begin
            last_valid_q <= 1'b1;
            last_idx_q   <= commit_idx;
            last_val_q   <= upd_val_d;
        end
    end

    // Control FSM with registered flush pulse and redirect PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BU_RUN;
            flush_q    <= 1'b0;
            redirect_q <= '0;
        end else begin
            case (state_q)
                BU_RUN: begin
                    if (accept && mispredict) begin
                        state_q    <= BU_FLUSH;
                        flush_q    <= 1'b1;
                        redirect_q <= commit_taken ? commit_target : commit_pc + 32'd4;
                    end else begin
                        flush_q <= 1'b0;
                    end
                end
                BU_FLUSH: begin
                    state_q <= BU_RUN;
                    flush_q <= 1'b0;
                end
                default: begin
                    state_q <= BU_RUN;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    assign flush_out   = flush_q;
    assign redirect_pc = redirect_q;

`ifdef BR_PERF_CTR_EN
    logic [31:0] perf_br_q;
    logic [31:0] perf_mis_q;

    // Saturating counts of accepted commits and accepted mispredicts.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_br_q  <= '0;
            perf_mis_q <= '0;
        end else begin
            if (accept && (perf_br_q != 32'hFFFF_FFFF)) begin
                perf_br_q <= perf_br_q + 32'd1;
            end
            if (accept && mispredict && (perf_mis_q != 32'hFFFF_FFFF)) begin
                perf_mis_q <= perf_mis_q + 32'd1;
            end
        end
    end

    assign perf_branches    = perf_br_q;
    assign perf_mispredicts = perf_mis_q;
`endif

endmodule

// File: tb/tb_branch_update_unit.sv
// Bench for branch_update_unit: directed commits plus a random
// mispredict-free burst, checked through an expected-write queue.
module tb_branch_update_unit;
    import branch_update_unit_pkg::*;

    localparam int IW = PATTERN_HISTORY_LEN;

    typedef struct packed {
        logic          fl;
        logic [31:0]   rd;
        logic [IW-1:0] idx;
        logic [1:0]    val;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          commit_valid;
    logic          commit_ready;
    logic [31:0]   commit_pc;
    logic [31:0]   commit_target;
    logic          commit_taken;
    logic [1:0]    commit_pred;
    logic [IW-1:0] commit_idx;
    logic          branch_write;
    logic [1:0]    updated_val;
    logic [IW-1:0] control_idx;
    logic          flush_out;
    logic [31:0]   redirect_pc;
`ifdef BR_PERF_CTR_EN
    logic [31:0]   perf_branches;
    logic [31:0]   perf_mispredicts;
`endif

    exp_t          exp_q[$];
    int            stamp_q[$];
    int            cyc = 0;
    int            n_assert = 0;
    int            n_fail = 0;
    int            n_acc = 0;
    int            n_mis = 0;
    bit            mon_en = 0;
    logic          mdl_valid = 0;
    logic [IW-1:0] mdl_idx = '0;
    logic [1:0]    mdl_val = 2'b00;

    branch_update_unit dut (
        .clk           (clk),
        .rst           (rst),
        .commit_valid  (commit_valid),
        .commit_ready  (commit_ready),
        .commit_pc     (commit_pc),
        .commit_target (commit_target),
        .commit_taken  (commit_taken),
        .commit_pred   (commit_pred),
        .commit_idx    (commit_idx),
        .branch_write  (branch_write),
        .updated_val   (updated_val),
        .control_idx   (control_idx),
        .flush_out     (flush_out),
        .redirect_pc   (redirect_pc)
`ifdef BR_PERF_CTR_EN
        ,
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
`endif
    );

    // Clock and cycle stamp
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference counter update from the bench's own view of the last update.
    function automatic logic [1:0] mdl_next(input logic tk, input logic [1:0] pr,
                                            input logic [IW-1:0] ix);
        logic [1:0] b;
        b = (mdl_valid && mdl_idx == ix) ? mdl_val : pr;
        if (tk) return (b == 2'b11) ? b : b + 2'd1;
        else    return (b == 2'b00) ? b : b - 2'd1;
    endfunction

    // Driver: present one commit (called just after a posedge), wait for the
    // handshake, queue the expected PHT write and flush, return after the edge.
    task automatic send(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                        input logic [1:0] pr, input logic [IW-1:0] ix, input logic [1:0] ev);
        exp_t e;
        int n;
        n = 0;
        commit_valid  = 1'b1;
        commit_pc     = pc;
        commit_target = tgt;
        commit_taken  = tk;
        commit_pred   = pr;
        commit_idx    = ix;
        @(negedge clk);
        while (!commit_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!commit_ready) begin
            check_eq("ready_timeout", commit_ready, 1'b1);
        end else begin
            e.fl  = (pr[1] != tk);
            e.rd  = tk ? tgt : pc + 32'd4;
            e.idx = ix;
            e.val = ev;
            exp_q.push_back(e);
            stamp_q.push_back(cyc);
            mdl_valid = 1'b1;
            mdl_idx   = ix;
            mdl_val   = ev;
            n_acc++;
            if (e.fl) n_mis++;
        end
        @(posedge clk);
        #1;
        commit_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare every PHT write, flush pulse and ready level.
    always @(negedge clk) begin
        exp_t e;
        logic exp_rdy;
        if (rst) begin
            exp_q.delete();
            stamp_q.delete();
        end else if (mon_en) begin
            while (stamp_q.size() > 0 && stamp_q[0] + 1 < cyc) begin
                check_eq("write_latency", 64'(stamp_q[0] + 1), 64'(cyc));
                void'(exp_q.pop_front());
                void'(stamp_q.pop_front());
            end
            exp_rdy = 1'b1;
            if (!branch_write) begin
                if (stamp_q.size() > 0 && stamp_q[0] < cyc) begin
                    e = exp_q.pop_front();
                    void'(stamp_q.pop_front());
                    check_eq("pht_idx", control_idx, e.idx);
                    check_eq("pht_val", updated_val, e.val);
                    check_eq("flush", flush_out, e.fl);
                    if (e.fl) begin
                        check_eq("redirect", redirect_pc, e.rd);
                        exp_rdy = 1'b0;
                    end
                end else begin
                    check_eq("unexpected_write", branch_write, 1'b1);
                end
            end else begin
                check_eq("flush_idle", flush_out, 1'b0);
            end
            check_eq("ready", commit_ready, exp_rdy);
        end
    end

    initial begin
        logic       tk;
        logic [1:0] pr;
        logic [IW-1:0] ix;
        rst           = 1'b1;
        commit_valid  = 1'b0;
        commit_pc     = '0;
        commit_target = '0;
        commit_taken  = 1'b0;
        commit_pred   = 2'b00;
        commit_idx    = '0;

        // 1: reset values, then idle after release
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", commit_ready, 1'b0);
        check_eq("rst_bw", branch_write, 1'b1);
        check_eq("rst_flush", flush_out, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", commit_ready, 1'b1);
        check_eq("post_rst_bw", branch_write, 1'b1);
        check_eq("post_rst_val", updated_val, 2'b00);
        check_eq("post_rst_idx", control_idx, 0);
        check_eq("post_rst_redirect", redirect_pc, 32'h0);
        mon_en = 1;
        @(posedge clk);
        #1;

        // 2: weakly-not-taken resolved taken -> 10, mispredict to target
        send(32'h100, 32'h140, 1'b1, 2'b01, IW'(10'h05A), 2'b10);
        idle(2);

        // 3: saturation holds at both ends, predictions correct
        send(32'h200, 32'h260, 1'b1, 2'b11, IW'(10'h011), 2'b11);
        send(32'h204, 32'h280, 1'b0, 2'b00, IW'(10'h022), 2'b00);
        idle(2);

        // 4: same entry twice; second update builds on the first
        send(32'h300, 32'h340, 1'b1, 2'b01, IW'(10'h010), 2'b10);
        send(32'h300, 32'h340, 1'b1, 2'b01, IW'(10'h010), 2'b11);
        idle(2);

        // not-taken mispredict at the top of the address space wraps to 0
        send(32'hFFFF_FFFC, 32'h0000_1000, 1'b0, 2'b11, IW'(10'h3FF), 2'b10);
        idle(2);

        // 5: continuous mispredict-free stream over two entries
        for (int i = 0; i < 10; i++) begin
            tk = 1'($urandom_range(0, 1));
            pr = {tk, 1'($urandom_range(0, 1))};
            ix = IW'(10'h300 + $urandom_range(0, 1));
            send(32'h400 + 32'(i * 4), 32'h800, tk, pr, ix, mdl_next(tk, pr, ix));
        end
        idle(2);

        // 6: mispredict, then reset during the flush cycle
        send(32'h1FC, 32'h300, 1'b0, 2'b10, IW'(10'h077), 2'b01);
        rst = 1'b1;
        mdl_valid = 1'b0;
        @(negedge clk);
        check_eq("f6_flush", flush_out, 1'b1);
        check_eq("f6_redirect", redirect_pc, 32'h200);
        check_eq("f6_ready", commit_ready, 1'b0);
        check_eq("f6_bw", branch_write, 1'b1);
`ifdef BR_PERF_CTR_EN
        check_eq("perf_branches", perf_branches, n_acc);
        check_eq("perf_mispredicts", perf_mispredicts, n_mis);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("f6_rst_bw", branch_write, 1'b1);
        check_eq("f6_rst_val", updated_val, 2'b00);
        check_eq("f6_rst_idx", control_idx, 0);
        check_eq("f6_rst_flush", flush_out, 1'b0);
        check_eq("f6_rst_redirect", redirect_pc, 32'h0);
        check_eq("f6_rst_ready", commit_ready, 1'b1);
`ifdef BR_PERF_CTR_EN
        check_eq("perf_rst", perf_branches, 32'h0);
`endif
        @(posedge clk);
        #1;

        // after reset the stale snapshot must not be bypassed
        send(32'h500, 32'h540, 1'b1, 2'b10, IW'(10'h010), 2'b11);
        idle(4);
        check_eq("drain_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
